silu_grad_pwl: RTL and testbench
================================

SILU_GRAD_PWL -- requirements
Module: silu_grad_pwl

Interface
- REQ-001: Parameters: none; all data is signed 16-bit Q6.9 two's complement (0x0200 = 1.0).
- REQ-002: clk  input  1  sole clock; all state on rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: in_valid  input  1  input beat valid.
- REQ-005: in_ready  output  1  block accepts beat this cycle.
- REQ-006: x  input  16  forward-pass activation input, Q6.9.
- REQ-007: dy  input  16  upstream gradient, Q6.9.
- REQ-008: out_valid  output  1  output beat valid.
- REQ-009: out_ready  input  1  downstream accepts beat.
- REQ-010: dx  output  16  dy * silu'(x), Q6.9.
- REQ-011: dx_sat  output  1  dx of this beat was clamped.

Function
- REQ-012: Transfer occurs on a cycle with valid and ready both high; the beat is held stable by the source until that transfer.
- REQ-013: Three-stage pipeline S1 (segment lookup, register derivative code d and dy), S2 (register 32-bit signed product dy*d), S3 (round, shift, saturate, register dx/dx_sat).
- REQ-014: Latency is exactly 3 cycles from input transfer to out_valid when out_ready stays high; throughput 1 beat/cycle.
- REQ-015: Stage k loads when it is empty or stage k+1 loads in the same cycle (bubble-collapsing); S3 unloads on output transfer; in_ready = S1 can load.
- REQ-016: Under stall, up to 3 beats are held, none dropped or duplicated, order preserved; dx/dx_sat stay constant while out_valid high and out_ready low.
- REQ-017: Segment selection is a signed compare of x against lower bounds; x equal to a bound selects the upper segment.
- REQ-018: Derivative LUT (lower bound -> d): below 0xF000 -> 0x0000; 0xF000 -> 0xFFF8; 0xF600 -> 0xFFE0; 0xFA00 -> 0xFFD0; 0xFC80 -> 0xFFF0; 0xFE00 -> 0x0050; 0xFF00 -> 0x00C0; 0x0000 -> 0x0140; 0x0100 -> 0x01B0; 0x0200 -> 0x0200; 0x0380 -> 0x0230; 0x0600 -> 0x0220; 0x0A00 -> 0x0208; 0x1000 and above -> 0x0200.
- REQ-019: Product is full 32-bit signed; result = product arithmetically shifted right 9 (rounding per REQ-024/025).
- REQ-020: Result above 0x7FFF clamps to 0x7FFF and below 0x8000 (signed) clamps to 0x8000, with dx_sat=1; otherwise dx_sat=0.
- REQ-021: dy is never modified before the multiply; x influences only d.

Reset
- REQ-022: rst_n low asynchronously clears all stage valid flags; out_valid=0, dx=0x0000, dx_sat=0 immediately; in_ready=0 while rst_n low.
- REQ-023: Beats in flight at reset assertion are discarded; first cycle after release in_ready=1, pipeline empty.

Configuration
- REQ-024: Macro SILU_GRAD_ROUND_EN defined: round half up, i.e. add 0x100 to product before the 9-bit arithmetic shift, then saturate.
- REQ-025: Macro not defined: truncate (floor) by plain 9-bit arithmetic shift; no rounding adder is built; all other behaviour identical.

Verification
- REQ-026: x=0x0000, dy=0x0200, out_ready=1 -> dx=0x0140, dx_sat=0, out_valid exactly 3 cycles after transfer.
- REQ-027: x=0xF100, dy=0x0400 -> dx=0xFFF0; x=0xF000 boundary, dy=0x0400 -> dx=0xFFF0; x=0xEFFF, dy=0x0400 -> dx=0x0000.
- REQ-028: x=0x0600, dy=0x7FFF -> dx=0x7FFF, dx_sat=1; x=0x0600, dy=0x8000 -> dx=0x8000, dx_sat=1.
- REQ-029: x=0x0100, dy=0x0001 -> dx=0x0001 with SILU_GRAD_ROUND_EN, dx=0x0000 without.
- REQ-030: 6 back-to-back beats, out_ready low for 5 cycles from first out_valid -> in_ready falls after 3 held beats, all 6 outputs emerge in order, held values stable.
- REQ-031: rst_n pulsed low with 2 beats in flight -> out_valid drops same cycle without clock edge; no stale beat emerges after release.

Source files
------------

// File: rtl/silu_grad_pwl_if.sv
// silu_grad_pwl_if: valid/ready beat bundle for the SiLU-gradient pipeline.
// master drives x/dy/in_valid and out_ready; slave is the pipeline itself.
interface silu_grad_pwl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] dy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dx;
    logic        dx_sat;

    modport master (
        output in_valid, x, dy, out_ready,
        input  in_ready, out_valid, dx, dx_sat
    );

    modport slave (
        input  in_valid, x, dy, out_ready,
        output in_ready, out_valid, dx, dx_sat
    );
endinterface

// File: rtl/silu_grad_pwl.sv
// silu_grad_pwl: 3-stage pipeline computing dx = dy * silu'(x) in Q6.9.
// Define SILU_GRAD_ROUND_EN for round-half-up; otherwise the result is floored.
module silu_grad_pwl (
    input  logic           clk,
    input  logic           rst_n,
    silu_grad_pwl_if.slave bus
);
    logic               r_v1;
    logic               r_v2;
    logic               r_v3;
    logic signed [15:0] r_d1;
    logic signed [15:0] r_dy1;
    logic signed [31:0] r_p2;
    logic        [15:0] r_dx;
    logic               r_sat;

    logic               w_ld1;
    logic               w_ld2;
    logic               w_ld3;
    logic signed [15:0] w_x;
    logic signed [15:0] w_d;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_adj;
    logic signed [31:0] w_sh;
    logic        [15:0] w_dx;
    logic               w_sat;

    // Bubble-collapsing load chain: a stage loads when empty or draining.
    assign w_ld3 = !r_v3 || bus.out_ready;
    assign w_ld2 = !r_v2 || w_ld3;
    assign w_ld1 = !r_v1 || w_ld2;

    assign bus.in_ready  = rst_n & w_ld1;
    assign bus.out_valid = r_v3;
    assign bus.dx        = r_dx;
    assign bus.dx_sat    = r_sat;

    assign w_x = $signed(bus.x);

    always_comb begin
        w_d = 16'sh0000;
        if (w_x >= 16'sh1000)      w_d = 16'sh0200;
        else if (w_x >= 16'sh0A00) w_d = 16'sh0208;
        else if (w_x >= 16'sh0600) w_d = 16'sh0220;
        else if (w_x >= 16'sh0380) w_d = 16'sh0230;
        else if (w_x >= 16'sh0200) w_d = 16'sh0200;
        else if (w_x >= 16'sh0100) w_d = 16'sh01B0;
        else if (w_x >= 16'sh0000) w_d = 16'sh0140;
        else if (w_x >= 16'shFF00) w_d = 16'sh00C0;
        else if (w_x >= 16'shFE00) w_d = 16'sh0050;
        else if (w_x >= 16'shFC80) w_d = 16'shFFF0;
        else if (w_x >= 16'shFA00) w_d = 16'shFFD0;
        else if (w_x >= 16'shF600) w_d = 16'shFFE0;
        else if (w_x >= 16'shF000) w_d = 16'shFFF8;
    end

    assign w_prod = 32'(r_dy1) * 32'(r_d1);

`ifdef SILU_GRAD_ROUND_EN
    assign w_adj = r_p2 + 32'sd256;
`else
    assign w_adj = r_p2;
`endif

    assign w_sh = w_adj >>> 9;

    always_comb begin
        w_dx  = w_sh[15:0];
        w_sat = 1'b0;
        if (w_sh > 32'sd32767) begin
            w_dx  = 16'h7FFF;
            w_sat = 1'b1;
        end else if (w_sh < -32'sd32768) begin
            w_dx  = 16'h8000;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_d1  <= '0;
            r_dy1 <= '0;
            r_p2  <= '0;
            r_dx  <= '0;
            r_sat <= 1'b0;
        end else begin
            if (w_ld1) begin
                r_v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    r_d1  <= w_d;
                    r_dy1 <= $signed(bus.dy);
                end
            end
            if (w_ld2) begin
                r_v2 <= r_v1;
                if (r_v1) r_p2 <= w_prod;
            end
            if (w_ld3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_dx  <= w_dx;
                    r_sat <= w_sat;
                end
            end
        end
    end
endmodule

// File: tb/tb_silu_grad_pwl.sv
// tb_silu_grad_pwl: directed and randomized checks of silu_grad_pwl
// against a table-driven arithmetic model of the SiLU-gradient transfer.
module tb_silu_grad_pwl;
    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    silu_grad_pwl_if bus();

    silu_grad_pwl dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    localparam int LO [13] = '{-4096, -2560, -1536, -896, -512, -256,
                               0, 256, 512, 896, 1536, 2560, 4096};
    localparam int DV [13] = '{-8, -32, -48, -16, 80, 192,
                               320, 432, 512, 560, 544, 520, 512};
    localparam logic [15:0] BND [13] = '{
        16'hF000, 16'hF600, 16'hFA00, 16'hFC80, 16'hFE00, 16'hFF00,
        16'h0000, 16'h0100, 16'h0200, 16'h0380, 16'h0600, 16'h0A00,
        16'h1000};

`ifdef SILU_GRAD_ROUND_EN
    localparam logic [15:0] SMALL_DX = 16'h0001;
`else
    localparam logic [15:0] SMALL_DX = 16'h0000;
`endif

    function automatic int ref_d(int xv);
        int d;
        d = 0;
        for (int i = 0; i < 13; i++)
            if (xv >= LO[i]) d = DV[i];
        return d;
    endfunction

    // Returns {dx_sat, dx}.
    function automatic logic [16:0] ref_dx(logic [15:0] xv, logic [15:0] dyv);
        longint p;
        longint q;
        p = longint'($signed(dyv)) * longint'(ref_d(int'($signed(xv))));
`ifdef SILU_GRAD_ROUND_EN
        p = p + 256;
`endif
        q = p / 512;
        if ((p % 512) != 0 && p < 0) q = q - 1;
        if (q > 32767) return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    function automatic logic [15:0] rand_x();
        int k;
        int o;
        if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, 12);
            o = $urandom_range(0, 2);
            return BND[k] + 16'(o) - 16'd1;
        end
        return 16'($urandom);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.x = '0;
        bus.dy = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.dx !== 16'h0000)
            $display("FAIL reset_dx got %h want 0000", bus.dx);
        else pass_cnt++;
        total_cnt++;
        if (bus.dx_sat !== 1'b0)
            $display("FAIL reset_dx_sat got %b want 0", bus.dx_sat);
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b0)
            $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL release_in_ready got %b want 1", bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic send_one(string nm, logic [15:0] xv, logic [15:0] dyv,
                            logic [15:0] wdx, logic wsat);
        int lat;
        logic [15:0] gdx;
        logic gsat;
        lat = 0;
        gdx = '0;
        gsat = 1'b0;
        @(negedge clk);
        bus.x = xv;
        bus.dy = dyv;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            #1;
            if (bus.out_valid) begin
                lat = k;
                gdx = bus.dx;
                gsat = bus.dx_sat;
            end else begin
                @(negedge clk);
            end
        end
        total_cnt++;
        if (lat != 3)
            $display("FAIL %s_latency got %0d want 3", nm, lat);
        else pass_cnt++;
        total_cnt++;
        if (gdx !== wdx)
            $display("FAIL %s_dx got %h want %h", nm, gdx, wdx);
        else pass_cnt++;
        total_cnt++;
        if (gsat !== wsat)
            $display("FAIL %s_sat got %b want %b", nm, gsat, wsat);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_directed();
        send_one("zero",     16'h0000, 16'h0200, 16'h0140, 1'b0);
        send_one("seg_f100", 16'hF100, 16'h0400, 16'hFFF0, 1'b0);
        send_one("bnd_f000", 16'hF000, 16'h0400, 16'hFFF0, 1'b0);
        send_one("below",    16'hEFFF, 16'h0400, 16'h0000, 1'b0);
        send_one("sat_pos",  16'h0600, 16'h7FFF, 16'h7FFF, 1'b1);
        send_one("sat_neg",  16'h0600, 16'h8000, 16'h8000, 1'b1);
        send_one("round",    16'h0100, 16'h0001, SMALL_DX, 1'b0);
        send_one("bnd_1000", 16'h1000, 16'hFC00, 16'hFC00, 1'b0);
    endtask

    task automatic test_random();
        logic [16:0] q[$];
        logic [16:0] e;
        bit pend;
        int nin;
        pend = 1'b0;
        nin = 0;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (!pend) begin
                bus.in_valid = (c < 300) && ($urandom_range(0, 3) != 0);
                bus.x = rand_x();
                bus.dy = 16'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                total_cnt++;
                if (q.size() == 0) begin
                    $display("FAIL rnd_extra got %h want none", bus.dx);
                end else begin
                    e = q.pop_front();
                    if ({bus.dx_sat, bus.dx} !== e)
                        $display("FAIL rnd_dx got %b/%h want %b/%h",
                                 bus.dx_sat, bus.dx, e[16], e[15:0]);
                    else pass_cnt++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_dx(bus.x, bus.dy));
                nin++;
            end
            pend = bus.in_valid && !bus.in_ready;
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (q.size() != 0 || nin == 0)
            $display("FAIL rnd_drain got %0d left %0d sent want 0 left", q.size(), nin);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [6];
        logic [15:0] dys [6];
        logic [16:0] q[$];
        logic [16:0] e;
        logic [15:0] hdx;
        logic hsat;
        int sent;
        int got;
        int stall;
        bit seen;
        sent = 0;
        got = 0;
        stall = 0;
        seen = 1'b0;
        hdx = '0;
        hsat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            xs[i] = rand_x();
            dys[i] = 16'($urandom);
        end
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            bus.in_valid = (sent < 6);
            if (sent < 6) begin
                bus.x = xs[sent];
                bus.dy = dys[sent];
            end
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                hdx = bus.dx;
                hsat = bus.dx_sat;
            end
            bus.out_ready = !(seen && stall < 5);
            #1;
            if (seen && stall < 5) begin
                total_cnt++;
                if (bus.out_valid !== 1'b1 || bus.dx !== hdx || bus.dx_sat !== hsat)
                    $display("FAIL b2b_hold got %b %h %b want 1 %h %b",
                             bus.out_valid, bus.dx, bus.dx_sat, hdx, hsat);
                else pass_cnt++;
                if (stall == 0) begin
                    total_cnt++;
                    if (bus.in_ready !== 1'b0 || sent != 3)
                        $display("FAIL b2b_full got rdy=%b sent=%0d want 0 3",
                                 bus.in_ready, sent);
                    else pass_cnt++;
                end
                stall++;
            end
            if (bus.out_valid && bus.out_ready) begin
                total_cnt++;
                if (q.size() == 0) begin
                    $display("FAIL b2b_extra got %h want none", bus.dx);
                end else begin
                    e = q.pop_front();
                    if ({bus.dx_sat, bus.dx} !== e)
                        $display("FAIL b2b_dx got %b/%h want %b/%h",
                                 bus.dx_sat, bus.dx, e[16], e[15:0]);
                    else pass_cnt++;
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_dx(bus.x, bus.dy));
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        total_cnt++;
        if (got != 6)
            $display("FAIL b2b_count got %0d want 6", got);
        else pass_cnt++;
    endtask

    task automatic test_reset_flight();
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.x = 16'h0000;
        bus.dy = 16'h0200;
        @(negedge clk);
        bus.x = 16'h0100;
        bus.dy = 16'h0400;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.dx !== 16'h0140)
            $display("FAIL flight_pre got %b %h want 1 0140", bus.out_valid, bus.dx);
        else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.dx !== 16'h0000 ||
            bus.dx_sat !== 1'b0 || bus.in_ready !== 1'b0)
            $display("FAIL flight_async got %b %h %b %b want 0 0000 0 0",
                     bus.out_valid, bus.dx, bus.dx_sat, bus.in_ready);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL flight_release got %b want 1", bus.in_ready);
        else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL flight_stale got %b want 0 cyc %0d", bus.out_valid, c);
            else pass_cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_flight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
